// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operator codes, FSM states and
// small decode helpers that the CPU decoder also uses.
package alu_pkg;

  localparam logic [3:0] OpSll  = 4'd0;
  localparam logic [3:0] OpSra  = 4'd1;
  localparam logic [3:0] OpSrl  = 4'd2;
  localparam logic [3:0] OpMulu = 4'd3;
  localparam logic [3:0] OpDivu = 4'd4;
  localparam logic [3:0] OpAdd  = 4'd5;
  localparam logic [3:0] OpSub  = 4'd6;
  localparam logic [3:0] OpAnd  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpXor  = 4'd9;
  localparam logic [3:0] OpNor  = 4'd10;
  localparam logic [3:0] OpSlt  = 4'd11;
  localparam logic [3:0] OpSltu = 4'd12;
  localparam logic [3:0] OpMuls = 4'd13;
  localparam logic [3:0] OpDivs = 4'd14;
  localparam logic [3:0] OpRsvd = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } alu_state_e;

  // Codes that go through the multi-cycle multiply/divide unit.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OpMulu) || (op == OpDivu) || (op == OpMuls) || (op == OpDivs);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OpDivu) || (op == OpDivs);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OpMuls) || (op == OpDivs);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// load latches magnitudes and sign flags, step runs one iteration, fix
// presents the sign-corrected result on lo_o/hi_o for the cycle it is high.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  // lo holds multiplier/quotient, hi holds partial product/remainder.
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d, m_q, m_d;
  logic               div_q, div_d;
  logic               flip_lo_q, flip_lo_d;
  logic               flip_hi_q, flip_hi_d;
  logic               sign_a, sign_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod_neg;

  // Operand signs, multiply partial sum and divide trial subtraction.
  always_comb begin
    sign_a   = is_signed_i & a_i[WIDTH-1];
    sign_b   = is_signed_i & b_i[WIDTH-1];
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // MSB set means the shifted remainder was smaller than the divisor.
    rem_diff = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
  end

  // Next-state for load and one iteration.
  always_comb begin
    lo_d      = lo_q;
    hi_d      = hi_q;
    m_d       = m_q;
    div_d     = div_q;
    flip_lo_d = flip_lo_q;
    flip_hi_d = flip_hi_q;
    if (load_i) begin
      lo_d      = sign_a ? -a_i : a_i;
      hi_d      = '0;
      m_d       = sign_b ? -b_i : b_i;
      div_d     = is_div_i;
      flip_lo_d = sign_a ^ sign_b;
      flip_hi_d = sign_a;
    end else if (step_i) begin
      if (div_q) begin
        if (!rem_diff[WIDTH]) begin
          hi_d = rem_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  // Sign correction applied on the output while fix is high.
  always_comb begin
    lo_o     = lo_q;
    hi_o     = hi_q;
    prod_neg = -{hi_q, lo_q};
    if (fix_i) begin
      if (div_q) begin
        if (flip_lo_q) lo_o = -lo_q;
        if (flip_hi_q) hi_o = -hi_q;
      end else if (flip_lo_q) begin
        {hi_o, lo_o} = prod_neg;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q      <= '0;
      hi_q      <= '0;
      m_q       <= '0;
      div_q     <= 1'b0;
      flip_lo_q <= 1'b0;
      flip_hi_q <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      m_q       <= m_d;
      div_q     <= div_d;
      flip_lo_q <= flip_lo_d;
      flip_hi_q <= flip_hi_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift/add ops complete at accept,
// multiply/divide run WIDTH iterations in muldiv_iter followed by a fix cycle.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operator,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             equal,
  output logic             div0
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             equal_q, equal_d;
  logic             div0_q, div0_d;
  logic             eq_pend_q, eq_pend_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result2_q, result2_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             md_load, md_step, md_fix;
  logic             md_is_div, md_is_signed;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign md_is_div    = is_div_op(operator);
  assign md_is_signed = is_signed_op(operator);

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (md_load),
    .step_i     (md_step),
    .fix_i      (md_fix),
    .is_div_i   (md_is_div),
    .is_signed_i(md_is_signed),
    .a_i        (x),
    .b_i        (y),
    .lo_o       (md_lo),
    .hi_o       (md_hi)
  );

  // Single-cycle datapath; iterative and reserved codes yield zero here.
  always_comb begin
    shamt   = y[SHW-1:0];
    alu_res = '0;
    unique case (operator)
      OpSll:   alu_res = x << shamt;
      OpSra:   alu_res = $signed(x) >>> shamt;
      OpSrl:   alu_res = x >> shamt;
      OpAdd:   alu_res = x + y;
      OpSub:   alu_res = x - y;
      OpAnd:   alu_res = x & y;
      OpOr:    alu_res = x | y;
      OpXor:   alu_res = x ^ y;
      OpNor:   alu_res = ~(x | y);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, x < y};
      default: alu_res = '0;
    endcase
  end

  // FSM next-state and output register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    equal_d   = equal_q;
    div0_d    = div0_q;
    eq_pend_d = eq_pend_q;
    result_d  = result_q;
    result2_d = result2_q;
    md_load   = 1'b0;
    md_step   = 1'b0;
    md_fix    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!is_iter_op(operator)) begin
            result_d  = alu_res;
            result2_d = '0;
            equal_d   = (x == y);
            div0_d    = 1'b0;
            done_d    = 1'b1;
          end else if (md_is_div && (y == '0)) begin
            // Divide by zero bypasses the iterative unit entirely.
            result_d  = '1;
            result2_d = x;
            equal_d   = (x == y);
            div0_d    = 1'b1;
            done_d    = 1'b1;
          end else begin
            md_load   = 1'b1;
            eq_pend_d = (x == y);
            cnt_d     = '0;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        md_step = 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + SHW'(1);
        end
      end
      StFix: begin
        md_fix    = 1'b1;
        result_d  = md_lo;
        result2_d = md_hi;
        equal_d   = eq_pend_q;
        div0_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      div0_q    <= 1'b0;
      eq_pend_q <= 1'b0;
      result_q  <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      equal_q   <= equal_d;
      div0_q    <= div0_d;
      eq_pend_q <= eq_pend_d;
      result_q  <= result_d;
      result2_q <= result2_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign result  = result_q;
  assign result2 = result2_q;
  assign equal   = equal_q;
  assign div0    = div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table, reset
// abort and back-to-back sequences, then random ops against a plain model.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  operator = 4'd0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        busy, done, equal, div0;
  logic [31:0] result, result2;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operator(operator),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .result2 (result2),
    .equal   (equal),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] r2;
    logic        eq;
    logic        d0;
    int          lat;
  } vec_t;

  vec_t vec[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [31:0] r2, output logic d0, output int lat);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = int'(b[4:0]);
    r = '0; r2 = '0; d0 = 1'b0; lat = 1;
    case (op)
      4'd0: r = a << sh;
      4'd1: r = 32'(sa >>> sh);
      4'd2: r = a >> sh;
      4'd3: begin p = ua * ub; r = p[31:0]; r2 = p[63:32]; lat = 34; end
      4'd4: if (b == 0) begin r = '1; r2 = a; d0 = 1'b1; end
            else begin r = 32'(ua / ub); r2 = 32'(ua % ub); lat = 34; end
      4'd5: r = a + b;
      4'd6: r = a - b;
      4'd7: r = a & b;
      4'd8: r = a | b;
      4'd9: r = a ^ b;
      4'd10: r = ~(a | b);
      4'd11: r = {31'b0, sa < sb};
      4'd12: r = {31'b0, a < b};
      4'd13: begin p = 64'(sa * sb); r = p[31:0]; r2 = p[63:32]; lat = 34; end
      4'd14: if (b == 0) begin r = '1; r2 = a; d0 = 1'b1; end
             else begin r = 32'(sa / sb); r2 = 32'(sa % sb); lat = 34; end
      default: r = '0;
    endcase
  endfunction

  // Issue one op (start for one edge), scramble inputs after accept, and wait
  // for done. Returns in the done cycle, #1 after the edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy1, output logic hold_ok);
    logic [31:0] prev_r, prev_r2;
    prev_r   = result;
    prev_r2  = result2;
    operator = op;
    x        = a;
    y        = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    x        = $urandom();
    y        = $urandom();
    operator = 4'($urandom_range(0, 15));
    busy1    = busy;
    hold_ok  = 1'b1;
    lat      = 1;
    while (!done && lat < 100) begin
      if (result !== prev_r || result2 !== prev_r2) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int          lat;
    logic        busy1, hold_ok, seen_done;
    logic [31:0] er, er2;
    logic        ed0;
    int          elat;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    vec[0]  = '{OpAdd,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
    vec[1]  = '{OpMuls, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    vec[2]  = '{OpDivs, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    vec[3]  = '{OpDivu, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b0, 1'b1, 1};
    vec[4]  = '{OpSra,  32'h80000000, 32'h00000024, 32'hF8000000, 32'h00000000, 1'b0, 1'b0, 1};
    vec[5]  = '{OpSlt,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1};
    vec[6]  = '{OpSltu, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
    vec[7]  = '{OpDivs, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 34};
    vec[8]  = '{OpDivu, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 34};
    vec[9]  = '{OpSub,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1};
    vec[10] = '{OpNor,  32'h0F0F0000, 32'h00F0000F, 32'hF000FFF0, 32'h00000000, 1'b0, 1'b0, 1};
    vec[11] = '{OpRsvd, 32'h00001234, 32'h00001234, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1};
    vec[12] = '{OpSll,  32'h00000001, 32'h0000003F, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1};
    vec[13] = '{OpSrl,  32'h80000000, 32'h0000001F, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1};
    vec[14] = '{OpDivs, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 1'b1, 1};
    vec[15] = '{OpMulu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 34};
    vec[16] = '{OpDivs, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 34};
    vec[17] = '{OpXor,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 32'h00000000, 1'b0, 1'b0, 1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset result", result, 32'h0);
    check("reset result2", result2, 32'h0);
    check("reset equal", 32'(equal), 32'h0);
    check("reset div0", 32'(div0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors; each op starts in the previous op's done cycle.
    for (int i = 0; i < 18; i++) begin
      run_op(vec[i].op, vec[i].a, vec[i].b, lat, busy1, hold_ok);
      check($sformatf("vec%0d result", i), result, vec[i].r);
      check($sformatf("vec%0d result2", i), result2, vec[i].r2);
      check($sformatf("vec%0d equal", i), 32'(equal), 32'(vec[i].eq));
      check($sformatf("vec%0d div0", i), 32'(div0), 32'(vec[i].d0));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vec[i].lat));
      check($sformatf("vec%0d busy", i), 32'(busy1), 32'(vec[i].lat > 1));
      check($sformatf("vec%0d hold", i), 32'(hold_ok), 32'h1);
    end

    // Leave non-zero outputs, then abort a MULU with reset at cycle 10.
    run_op(OpAdd, 32'd5, 32'd5, lat, busy1, hold_ok);
    check("pre-abort result", result, 32'd10);
    operator  = OpMulu;
    x         = 32'h00010000;
    y         = 32'h00010000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (done) seen_done = 1'b1;
      start = (c == 5);
      if (c == 5) begin
        operator = OpAdd;
        x = 32'd1;
        y = 32'd2;
      end
      if (c < 10) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    check("abort busy before rst", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    check("abort result", result, 32'h0);
    check("abort result2", result2, 32'h0);
    check("abort equal", 32'(equal), 32'h0);
    check("abort div0", 32'(div0), 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("abort no done pulse", 32'(seen_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("post-release busy", 32'(busy), 32'h0);

    // MULU after release, with a second op started in the done cycle.
    run_op(OpMulu, 32'h00010000, 32'h00010000, lat, busy1, hold_ok);
    check("b2b mulu latency", 32'(lat), 32'd34);
    check("b2b mulu result", result, 32'h0);
    check("b2b mulu result2", result2, 32'h1);
    check("b2b mulu div0", 32'(div0), 32'h0);
    run_op(OpAdd, 32'd2, 32'd3, lat, busy1, hold_ok);
    check("b2b add latency", 32'(lat), 32'd1);
    check("b2b add result", result, 32'd5);
    @(posedge clk);
    #1;
    check("done single pulse", 32'(done), 32'h0);
    check("result held", result, 32'd5);

    // Random ops against the model.
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom();
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = ra;
        2: rb = 32'($urandom_range(0, 40));
        3: rb = 32'hFFFFFFFF;
        default: rb = $urandom();
      endcase
      ref_model(rop, ra, rb, er, er2, ed0, elat);
      run_op(rop, ra, rb, lat, busy1, hold_ok);
      check($sformatf("rnd%0d op%0d result", i, rop), result, er);
      check($sformatf("rnd%0d op%0d result2", i, rop), result2, er2);
      check($sformatf("rnd%0d op%0d equal", i, rop), 32'(equal), 32'(ra == rb));
      check($sformatf("rnd%0d op%0d div0", i, rop), 32'(div0), 32'(ed0));
      check($sformatf("rnd%0d op%0d latency", i, rop), 32'(lat), 32'(elat));
      check($sformatf("rnd%0d op%0d hold", i, rop), 32'(hold_ok), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
